// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared state encoding, vector defaults and RETI opcode for int_ctrl
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam int unsigned DEF_VEC_BASE   = 32'h3C0;
  localparam int unsigned DEF_VEC_STRIDE = 32'd4;

  // Opcode uc decodes into the reti strobe
  localparam logic [5:0] RETI_OPCODE = 6'b110111;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// rtl/int_ctrl_prio_enc.sv - combinational priority encoder, lowest set index wins
module prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last assignment
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt sequencer: latches irq edges, vectors the PC, saves/restores PC and Z
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          NIRQ       = 4,
  parameter int          PCW        = 10,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_in,
  input  logic            gie,
  input  logic [PCW-1:0]  pc,
  input  logic            z,
  input  logic            reti,
  output logic            pc_load,
  output logic [PCW-1:0]  pc_target,
  output logic            squash,
  output logic            z_restore,
  output logic            z_saved,
  output logic            int_active,
  output logic [2:0]      int_id
);

  localparam logic [PCW-1:0] BASE_W   = PCW'(VEC_BASE);
  localparam logic [PCW-1:0] STRIDE_W = PCW'(VEC_STRIDE);

  state_t          state, state_nx;
  logic [NIRQ-1:0] irq_q, pend, mask;
  logic [NIRQ-1:0] rise, clr, eligible;
  logic [PCW-1:0]  saved_pc;
  logic [PCW-1:0]  vec_addr;
  logic [2:0]      id_q, enc_idx;
  logic            enc_valid;
  logic            z_q;

  assign rise     = irq & ~irq_q;
  assign eligible = pend & mask & {NIRQ{gie}};
  assign vec_addr = BASE_W + PCW'(id_q) * STRIDE_W;

  // Only the source being taken is cleared; a same-cycle edge re-pends it below
  always_comb begin
    clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr[i] = (state == ST_TAKE) && (id_q == 3'(i));
    end
  end

  prio_enc #(.N(NIRQ)) u_prio_enc (
    .req   (eligible),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      irq_q    <= '0;
      pend     <= '0;
      mask     <= '0;
      saved_pc <= '0;
      z_q      <= 1'b0;
      id_q     <= 3'd0;
    end else begin
      state <= state_nx;
      irq_q <= irq;
      pend  <= (pend & ~clr) | rise;
      if (mask_we) begin
        mask <= mask_in;
      end
      if (state == ST_IDLE && enc_valid) begin
        id_q <= enc_idx;
      end
      if (state == ST_TAKE) begin
        saved_pc <= pc;
        z_q      <= z;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pc_load    = 1'b0;
    pc_target  = '0;
    squash     = 1'b0;
    z_restore  = 1'b0;
    int_active = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          state_nx = ST_TAKE;
        end
      end
      ST_TAKE: begin
        pc_load    = 1'b1;
        pc_target  = vec_addr;
        squash     = 1'b1;
        int_active = 1'b1;
        state_nx   = ST_SERVICE;
      end
      ST_SERVICE: begin
        int_active = 1'b1;
        if (reti) begin
          pc_load   = 1'b1;
          pc_target = saved_pc;
          z_restore = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign int_id  = id_q;
  assign z_saved = z_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed and randomized checks of int_ctrl against an event-level reference model
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       gie;
  logic [9:0] pc;
  logic       z;
  logic       reti;
  logic       pc_load;
  logic [9:0] pc_target;
  logic       squash;
  logic       z_restore;
  logic       z_saved;
  logic       int_active;
  logic [2:0] int_id;

  int checks = 0;
  int errors = 0;
  int squash_seen = 0;

  // Reference model: pending requests, mask, and where the handler is in its life
  logic [3:0] m_pend, m_mask, m_prev;
  logic       m_take, m_serv, m_zs;
  logic [9:0] m_saved;
  int         m_id;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .gie        (gie),
    .pc         (pc),
    .z          (z),
    .reti       (reti),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .squash     (squash),
    .z_restore  (z_restore),
    .z_saved    (z_saved),
    .int_active (int_active),
    .int_id     (int_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_prev  = '0;
    m_take  = 1'b0;
    m_serv  = 1'b0;
    m_zs    = 1'b0;
    m_saved = '0;
    m_id    = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    chk({tag, "_pc_target"}, 32'(pc_target), 32'd0);
    chk({tag, "_squash"}, 32'(squash), 32'd0);
    chk({tag, "_z_restore"}, 32'(z_restore), 32'd0);
    chk({tag, "_z_saved"}, 32'(z_saved), 32'd0);
    chk({tag, "_int_active"}, 32'(int_active), 32'd0);
    chk({tag, "_int_id"}, 32'(int_id), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model with this cycle's inputs
  task automatic step();
    logic [3:0] rise;
    logic       ret;
    logic [9:0] tgt;
    logic       found;
    @(negedge clk);
    ret = m_serv && reti;
    tgt = m_take ? 10'(32'h3C0 + 32'(m_id) * 4) : (ret ? m_saved : 10'h000);
    chk("pc_load", 32'(pc_load), 32'(m_take || ret));
    chk("pc_target", 32'(pc_target), 32'(tgt));
    chk("squash", 32'(squash), 32'(m_take));
    chk("z_restore", 32'(z_restore), 32'(ret));
    chk("z_saved", 32'(z_saved), 32'(m_zs));
    chk("int_active", 32'(int_active), 32'(m_take || m_serv));
    chk("int_id", 32'(int_id), 32'(m_id));
    if (squash === 1'b1) squash_seen++;
    @(posedge clk);
    rise = irq & ~m_prev;
    if (m_take) begin
      m_pend[m_id] = 1'b0;
      m_saved = pc;
      m_zs    = z;
      m_take  = 1'b0;
      m_serv  = 1'b1;
    end else if (m_serv) begin
      if (reti) m_serv = 1'b0;
    end else begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!found && m_pend[i] && m_mask[i] && gie) begin
          found  = 1'b1;
          m_id   = i;
          m_take = 1'b1;
        end
      end
    end
    m_pend = m_pend | rise;
    if (mask_we) m_mask = mask_in;
    m_prev = irq;
    #1;
  endtask

  initial begin
    irq = '0; mask_we = 1'b0; mask_in = '0; gie = 1'b0;
    pc = '0; z = 1'b0; reti = 1'b0;
    model_reset();
    do_reset();

    // Single source: take, capture, return
    gie = 1'b1; mask_we = 1'b1; mask_in = 4'b0001; step();
    mask_we = 1'b0; irq = 4'b0001; step();
    irq = 4'b0000; step();
    pc = 10'h012; z = 1'b1; #1;
    chk("t2_pc_load", 32'(pc_load), 32'd1);
    chk("t2_squash", 32'(squash), 32'd1);
    chk("t2_target", 32'(pc_target), 32'h3C0);
    step();
    pc = 10'h055; z = 1'b0; #1;
    chk("t2_z_saved", 32'(z_saved), 32'd1);
    chk("t2_active", 32'(int_active), 32'd1);
    reti = 1'b1; #1;
    chk("t3_pc_load", 32'(pc_load), 32'd1);
    chk("t3_target", 32'(pc_target), 32'h012);
    chk("t3_z_restore", 32'(z_restore), 32'd1);
    step();
    reti = 1'b0; #1;
    chk("t3_idle_active", 32'(int_active), 32'd0);
    chk("t3_idle_pc_load", 32'(pc_load), 32'd0);
    step();

    // Two simultaneous edges: lower index first, one idle cycle, then the other
    mask_we = 1'b1; mask_in = 4'hF; step();
    mask_we = 1'b0; irq = 4'b1010; step();
    irq = 4'b0000; step();
    #1;
    chk("t4_first_id", 32'(int_id), 32'd1);
    chk("t4_first_target", 32'(pc_target), 32'h3C4);
    step();
    reti = 1'b1; step();
    reti = 1'b0; #1;
    chk("t4_gap_pc_load", 32'(pc_load), 32'd0);
    chk("t4_gap_active", 32'(int_active), 32'd0);
    step();
    #1;
    chk("t4_second_id", 32'(int_id), 32'd3);
    chk("t4_second_target", 32'(pc_target), 32'h3CC);
    chk("t4_second_load", 32'(pc_load), 32'd1);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Masked source waits for a mask write, then takes two cycles after it
    mask_we = 1'b1; mask_in = 4'h0; step();
    mask_we = 1'b0; irq = 4'b0100; step();
    irq = 4'b0000;
    repeat (4) step();
    #1;
    chk("t5_masked_active", 32'(int_active), 32'd0);
    mask_we = 1'b1; mask_in = 4'h4; step();
    mask_we = 1'b0; step();
    #1;
    chk("t5_take_load", 32'(pc_load), 32'd1);
    chk("t5_take_id", 32'(int_id), 32'd2);
    chk("t5_take_target", 32'(pc_target), 32'h3C8);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Re-edge during TAKE keeps the request pending
    mask_we = 1'b1; mask_in = 4'hF; step();
    mask_we = 1'b0; irq = 4'b0001; step();
    irq = 4'b0000; step();
    irq = 4'b0001; step();
    irq = 4'b0000; reti = 1'b1; step();
    reti = 1'b0; #1;
    chk("t6a_gap_pc_load", 32'(pc_load), 32'd0);
    step();
    #1;
    chk("t6a_again_load", 32'(pc_load), 32'd1);
    chk("t6a_again_id", 32'(int_id), 32'd0);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Held line yields one request; reti while idle is ignored
    squash_seen = 0;
    irq = 4'b0001; reti = 1'b1;
    repeat (20) step();
    irq = 4'b0000; reti = 1'b0;
    repeat (4) step();
    chk("t6b_takes", 32'(squash_seen), 32'd1);

    // Reset in the middle of a handler drops mask, pending and saved state
    irq = 4'b0010; step();
    irq = 4'b0000; step();
    pc = 10'h2AB; z = 1'b1; step();
    #1;
    chk("t1_in_service", 32'(int_active), 32'd1);
    reset = 1'b1; #1;
    check_all_zero("t1_midreset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    irq = 4'b0010; step();
    irq = 4'b0000;
    repeat (4) step();
    #1;
    chk("t1_no_take", 32'(int_active), 32'd0);
    mask_we = 1'b1; mask_in = 4'b0010; step();
    mask_we = 1'b0; step();
    #1;
    chk("t1_take_load", 32'(pc_load), 32'd1);
    chk("t1_take_id", 32'(int_id), 32'd1);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      mask_we = ($urandom_range(0, 9) == 0);
      mask_in = 4'($urandom);
      gie     = ($urandom_range(0, 7) != 0);
      pc      = 10'($urandom);
      z       = 1'($urandom);
      reti    = m_serv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
